ex_muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit, attached beside the EX-stage ALU.

---
 rtl/ex_muldiv_unit_pkg.sv | 39 +++
 rtl/ex_muldiv_unit_if.sv | 34 +++
 rtl/ex_muldiv_unit_step.sv | 41 ++++
 rtl/ex_muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_muldiv_unit_pkg                                        |
// | Brief    : funct3 codes, FSM encoding and decode helpers (RV32M)     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package ex_muldiv_unit_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic is_div(input logic [2:0] code);
    return code[2];
  endfunction

  // MUL keeps its low half under either signedness, so it runs unsigned.
  function automatic logic rs1_signed(input logic [2:0] code);
    return (code == MD_MULH) || (code == MD_MULHSU) || (code == MD_DIV) || (code == MD_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] code);
    return (code == MD_MULH) || (code == MD_DIV) || (code == MD_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_muldiv_unit_if                                         |
// | Brief    : EX-side request / MA-side result bundle of the M unit     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            md_start_ex;
  logic            cpu_stat_ex;
  logic            md_kill_ex;
  logic [2:0]      md_code_ex;
  logic [XLEN-1:0] rs1_data_ex;
  logic [XLEN-1:0] rs2_data_ex;
  logic [4:0]      rd_adr_ex;
  logic            md_stall_ex;
  logic            md_valid_ma;
  logic [XLEN-1:0] md_rd_data_ma;
  logic [4:0]      md_rd_adr_ma;

  modport master (
    output md_start_ex, cpu_stat_ex, md_kill_ex, md_code_ex,
           rs1_data_ex, rs2_data_ex, rd_adr_ex,
    input  md_stall_ex, md_valid_ma, md_rd_data_ma, md_rd_adr_ma
  );

  modport slave (
    input  md_start_ex, cpu_stat_ex, md_kill_ex, md_code_ex,
           rs1_data_ex, rs2_data_ex, rd_adr_ex,
    output md_stall_ex, md_valid_ma, md_rd_data_ma, md_rd_adr_ma
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : muldiv_step                                               |
// | Brief    : one radix-2 iteration: shift-add multiply or restoring    |
// |            divide on the {hi,lo} accumulator pair                    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div_mode,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shl;
  logic [XLEN-1:0] w_diff;

  always_comb begin
    w_sum  = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
    w_shl  = {hi_in, lo_in[XLEN-1]};
    // Only used when w_shl >= operand, so the remainder always fits XLEN bits.
    w_diff = w_shl[XLEN-1:0] - operand;
    if (div_mode) begin
      if (w_shl >= {1'b0, operand}) begin
        hi_out = w_diff;
        lo_out = {lo_in[XLEN-2:0], 1'b1};
      end else begin
        hi_out = w_shl[XLEN-1:0];
        lo_out = {lo_in[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_out = w_sum[XLEN:1];
      lo_out = {w_sum[0], lo_in[XLEN-1:1]};
    end
  end
endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_muldiv_unit                                            |
// | Brief    : iterative RV32M multiply/divide beside the EX-stage ALU;  |
// |            optional MULDIV_EARLY_OUT_EN skips CALC for zero operands |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ex_muldiv_unit_if.slave   md_if
);
  localparam int N  = XLEN / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  md_state_e         r_state;
  md_state_e         w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_op;
  logic [2:0]        r_code;
  logic [4:0]        r_adr;
  logic              r_s1;
  logic              r_s2;

  logic              w_start;
  logic              w_s1;
  logic              w_s2;
  logic              w_div;
  logic              w_early;
  logic [XLEN-1:0]   w_abs1;
  logic [XLEN-1:0]   w_abs2;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_result;
  logic [XLEN-1:0]   w_hi [UNROLL+1];
  logic [XLEN-1:0]   w_lo [UNROLL+1];

  assign w_start = md_if.md_start_ex & md_if.cpu_stat_ex & ~md_if.md_kill_ex;
  assign w_div   = is_div(md_if.md_code_ex);
  assign w_s1    = rs1_signed(md_if.md_code_ex) & md_if.rs1_data_ex[XLEN-1];
  assign w_s2    = rs2_signed(md_if.md_code_ex) & md_if.rs2_data_ex[XLEN-1];
  assign w_abs1  = w_s1 ? -md_if.rs1_data_ex : md_if.rs1_data_ex;
  assign w_abs2  = w_s2 ? -md_if.rs2_data_ex : md_if.rs2_data_ex;

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = w_div ? (md_if.rs2_data_ex == '0)
                         : ((md_if.rs1_data_ex == '0) || (md_if.rs2_data_ex == '0));
`else
  assign w_early = 1'b0;
`endif

  assign w_hi[0] = r_hi;
  assign w_lo[0] = r_lo;

  generate
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
      muldiv_step #(.XLEN(XLEN)) u_step (
        .div_mode (is_div(r_code)),
        .hi_in    (w_hi[gi]),
        .lo_in    (w_lo[gi]),
        .operand  (r_op),
        .hi_out   (w_hi[gi+1]),
        .lo_out   (w_lo[gi+1])
      );
    end
  endgenerate

  // Magnitude result in {r_hi,r_lo}: product for mul, {remainder,quotient} for div.
  always_comb begin
    w_prod   = {r_hi, r_lo};
    w_quo    = r_lo;
    w_rem    = r_hi;
    w_result = '0;
    if (r_s1 ^ r_s2)                 w_prod = -w_prod;
    if ((r_s1 ^ r_s2) && (r_op != '0)) w_quo  = -r_lo;
    if (r_s1)                        w_rem  = -r_hi;
    case (r_code)
      MD_MUL:                       w_result = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_result = w_quo;
      MD_REM, MD_REMU:              w_result = w_rem;
      default:                      w_result = '0;
    endcase
  end

  always_comb begin
    w_state_nxt       = r_state;
    md_if.md_stall_ex = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          md_if.md_stall_ex = 1'b1;
          w_state_nxt       = w_early ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        md_if.md_stall_ex = 1'b1;
        if (md_if.md_kill_ex)             w_state_nxt = ST_IDLE;
        else if (r_cnt == CW'(N - 1))     w_state_nxt = ST_FIX;
      end
      ST_FIX: begin
        md_if.md_stall_ex = 1'b1;
        w_state_nxt       = md_if.md_kill_ex ? ST_IDLE : ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt               <= '0;
      r_hi                <= '0;
      r_lo                <= '0;
      r_op                <= '0;
      r_code              <= '0;
      r_adr               <= '0;
      r_s1                <= 1'b0;
      r_s2                <= 1'b0;
      md_if.md_valid_ma   <= 1'b0;
      md_if.md_rd_data_ma <= '0;
      md_if.md_rd_adr_ma  <= '0;
    end else begin
      md_if.md_valid_ma <= (r_state == ST_FIX) && !md_if.md_kill_ex;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_code <= md_if.md_code_ex;
            r_adr  <= md_if.rd_adr_ex;
            r_s1   <= w_s1;
            r_s2   <= w_s2;
            r_op   <= w_abs2;
            r_cnt  <= '0;
            // Early-out preloads the final magnitudes the iteration would reach.
            if (w_early) begin
              r_hi <= w_div ? w_abs1 : '0;
              r_lo <= w_div ? '1 : '0;
            end else begin
              r_hi <= '0;
              r_lo <= w_abs1;
            end
          end
        end
        ST_CALC: begin
          r_hi  <= w_hi[UNROLL];
          r_lo  <= w_lo[UNROLL];
          r_cnt <= r_cnt + CW'(1);
        end
        ST_FIX: begin
          if (!md_if.md_kill_ex) begin
            md_if.md_rd_data_ma <= w_result;
            md_if.md_rd_adr_ma  <= r_adr;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ex_muldiv_unit                                         |
// | Brief    : directed self-checking bench, UNROLL=1 and UNROLL=4 DUTs  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_Z = 2;
`else
  localparam int LAT_Z = 34;
`endif
  localparam int LAT = 34;

  logic clk = 1'b0;
  logic rst_n;
  logic rst4_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.XLEN(32)) mif  ();
  ex_muldiv_unit_if #(.XLEN(32)) mif4 ();

  ex_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut  (.clk(clk), .rst_n(rst_n),  .md_if(mif.slave));
  ex_muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (.clk(clk), .rst_n(rst4_n), .md_if(mif4.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after DONE.
  task automatic run_op(input string tag, input logic [2:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int   cyc;
    logic stall_bad;
    mif.md_code_ex  = code;
    mif.rs1_data_ex = a;
    mif.rs2_data_ex = b;
    mif.rd_adr_ex   = rd;
    mif.md_start_ex = 1'b1;
    #1;
    check({tag, "_stall_c0"}, {31'd0, mif.md_stall_ex}, 32'd1);
    cyc       = 0;
    stall_bad = 1'b0;
    while (mif.md_valid_ma !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (mif.md_valid_ma !== 1'b1 && mif.md_stall_ex !== 1'b1) stall_bad = 1'b1;
    end
    mif.md_start_ex = 1'b0;
    check({tag, "_latency"},   cyc,                         exp_lat);
    check({tag, "_data"},      mif.md_rd_data_ma,           exp);
    check({tag, "_adr"},       {27'd0, mif.md_rd_adr_ma},   {27'd0, rd});
    check({tag, "_stall_dn"},  {31'd0, mif.md_stall_ex},    32'd0);
    check({tag, "_stall_run"}, {31'd0, stall_bad},          32'd0);
    @(posedge clk); #1;
    check({tag, "_valid_1cy"}, {31'd0, mif.md_valid_ma},    32'd0);
    check({tag, "_data_hold"}, mif.md_rd_data_ma,           exp);
  endtask

  initial begin
    int cyc4;
    rst_n  = 1'b0;
    rst4_n = 1'b0;
    mif.md_start_ex  = 1'b0; mif.cpu_stat_ex  = 1'b1; mif.md_kill_ex  = 1'b0;
    mif.md_code_ex   = '0;   mif.rs1_data_ex  = '0;   mif.rs2_data_ex = '0; mif.rd_adr_ex = '0;
    mif4.md_start_ex = 1'b0; mif4.cpu_stat_ex = 1'b1; mif4.md_kill_ex = 1'b0;
    mif4.md_code_ex  = '0;   mif4.rs1_data_ex = '0;   mif4.rs2_data_ex = '0; mif4.rd_adr_ex = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, mif.md_valid_ma},  32'd0);
    check("rst_data",  mif.md_rd_data_ma,         32'd0);
    check("rst_adr",   {27'd0, mif.md_rd_adr_ma}, 32'd0);
    check("rst_stall", {31'd0, mif.md_stall_ex},  32'd0);
    rst_n  = 1'b1;
    rst4_n = 1'b1;
    @(posedge clk); #1;

    // cpu_stat_ex low: start must be ignored
    mif.md_start_ex = 1'b1;
    mif.cpu_stat_ex = 1'b0;
    #1;
    check("nostat_stall", {31'd0, mif.md_stall_ex}, 32'd0);
    mif.md_start_ex = 1'b0;
    mif.cpu_stat_ex = 1'b1;
    @(posedge clk); #1;

    run_op("mul",     MD_MUL,    32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, LAT);
    run_op("mulh",    MD_MULH,   32'h80000000,  32'h80000000, 5'd6,  32'h40000000, LAT);
    run_op("mulhu",   MD_MULHU,  32'h80000000,  32'h80000000, 5'd7,  32'h40000000, LAT);
    run_op("mulhsu",  MD_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, LAT);
    run_op("div",     MD_DIV,    32'hFFFFFFF9,  32'd2,        5'd9,  32'hFFFFFFFD, LAT);
    run_op("rem",     MD_REM,    32'hFFFFFFF9,  32'd2,        5'd10, 32'hFFFFFFFF, LAT);
    run_op("div_ovf", MD_DIV,    32'h80000000,  32'hFFFFFFFF, 5'd11, 32'h80000000, LAT);
    run_op("rem_ovf", MD_REM,    32'h80000000,  32'hFFFFFFFF, 5'd12, 32'h00000000, LAT);
    run_op("divu",    MD_DIVU,   32'd1000,      32'd7,        5'd13, 32'd142,      LAT);
    run_op("remu",    MD_REMU,   32'd1000,      32'd7,        5'd14, 32'd6,        LAT);
    run_op("div_z",   MD_DIV,    32'hFFFFFFF9,  32'd0,        5'd15, 32'hFFFFFFFF, LAT_Z);
    run_op("rem_z",   MD_REM,    32'hFFFFFFF9,  32'd0,        5'd16, 32'hFFFFFFF9, LAT_Z);
    run_op("divu_z",  MD_DIVU,   32'd5,         32'd0,        5'd17, 32'hFFFFFFFF, LAT_Z);

    // kill at cycle 10 of a DIVU
    mif.md_code_ex  = MD_DIVU;
    mif.rs1_data_ex = 32'd1000;
    mif.rs2_data_ex = 32'd3;
    mif.rd_adr_ex   = 5'd30;
    mif.md_start_ex = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    mif.md_kill_ex  = 1'b1;
    mif.md_start_ex = 1'b0;
    @(posedge clk); #1;
    mif.md_kill_ex  = 1'b0;
    #1;
    check("kill_idle_stall", {31'd0, mif.md_stall_ex}, 32'd0);
    check("kill_no_valid",   {31'd0, mif.md_valid_ma}, 32'd0);
    @(posedge clk); #1;
    run_op("mul_after_kill", MD_MUL, 32'd12345, 32'd678, 5'd21, 32'd8369910, LAT);

    // UNROLL=4 instance
    mif4.md_code_ex  = MD_DIVU;
    mif4.rs1_data_ex = 32'd100;
    mif4.rs2_data_ex = 32'd7;
    mif4.rd_adr_ex   = 5'd9;
    mif4.md_start_ex = 1'b1;
    cyc4 = 0;
    while (mif4.md_valid_ma !== 1'b1 && cyc4 < 100) begin
      @(posedge clk); #1;
      cyc4++;
    end
    mif4.md_start_ex = 1'b0;
    check("u4_latency", cyc4,                        10);
    check("u4_data",    mif4.md_rd_data_ma,          32'd14);
    check("u4_adr",     {27'd0, mif4.md_rd_adr_ma},  32'd9);
    @(posedge clk); #1;

    // async reset mid-CALC on the UNROLL=4 instance
    mif4.rd_adr_ex   = 5'd3;
    mif4.md_start_ex = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mif4.md_start_ex = 1'b0;
    check("u4_calc_stall", {31'd0, mif4.md_stall_ex}, 32'd1);
    #2;
    rst4_n = 1'b0;
    #1;
    check("u4_rst_valid", {31'd0, mif4.md_valid_ma},  32'd0);
    check("u4_rst_data",  mif4.md_rd_data_ma,         32'd0);
    check("u4_rst_adr",   {27'd0, mif4.md_rd_adr_ma}, 32'd0);
    check("u4_rst_stall", {31'd0, mif4.md_stall_ex},  32'd0);
    @(posedge clk); #1;
    rst4_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    check("u4_post_rst_valid", {31'd0, mif4.md_valid_ma}, 32'd0);
    check("u4_post_rst_stall", {31'd0, mif4.md_stall_ex}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
